// File: rtl/sequenciador_linha_pkg.sv
// Shared definitions for the bottling-line sequencer: state codes (also
// decoded on the debug LEDs), the dozen constant and the 50 MHz cycle counts.
package sequenciador_linha_pkg;

   typedef enum logic [3:0] {
      S_IDLE       = 4'd0,
      S_MOVE_ENCH  = 4'd1,
      S_ENCHER     = 4'd2,
      S_MOVE_VED   = 4'd3,
      S_VEDAR      = 4'd4,
      S_MOVE_CQ    = 4'd5,
      S_INSPEC     = 4'd6,
      S_MOVE_SAIDA = 4'd7,
      S_FIM_LOTE   = 4'd8,
      S_FALHA      = 4'd9
   } estado_t;

   localparam int DUZIA                 = 12;
   localparam int CICLOS_MOVE_PADRAO    = 50_000_000;   // 1 s at 50 MHz
   localparam int CICLOS_TIMEOUT_PADRAO = 500_000_000;  // 10 s at 50 MHz
   localparam int TMR_W                 = 32;

   // Conveyor moves that end at a station; leaving one starts a timeout window.
   function automatic logic move_para_estacao(input estado_t e);
      return (e == S_MOVE_ENCH) || (e == S_MOVE_VED) || (e == S_MOVE_CQ);
   endfunction

   // Any conveyor move, including the exit move.
   function automatic logic eh_movimento(input estado_t e);
      return move_para_estacao(e) || (e == S_MOVE_SAIDA);
   endfunction

endpackage

// File: rtl/sequenciador_linha_temporizador_ciclos.sv
// Loadable down-counter shared by the conveyor move timer and the station
// timeout. Load has priority over clear; enable low freezes the count.
// done_o is high while the count sits at zero.
module sequenciador_linha_temporizador_ciclos #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   input  logic         en_i,
   output logic         done_o
);

   localparam logic [W-1:0] UM = W'(1);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: load, clear, or decrement while enabled and not yet at zero.
   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (clear_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - UM;
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);

endmodule

// File: rtl/sequenciador_linha.sv
// Master sequencer for the wine bottling line: moves each bottle through
// fill, seal and quality control, counts approved bottles against the batch
// target and declares a sticky fault if a station stalls.
// Optional build macro CONTAGEM_REJEITO_EN adds a rejected-bottle counter
// and a fault after MAX_REJ_SEGUIDAS consecutive rejections.
module sequenciador_linha
   import sequenciador_linha_pkg::*;
#(
   parameter int MOVE_CYCLES    = CICLOS_MOVE_PADRAO,
   parameter int TIMEOUT_CYCLES = CICLOS_TIMEOUT_PADRAO,
`ifdef CONTAGEM_REJEITO_EN
   parameter int MAX_REJ_SEGUIDAS = 3,
`endif
   parameter int LOTE_DUZIAS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       parar,
   input  logic       enchimento_concluido,
   input  logic       vedacao_concluida,
   input  logic       cq_concluida,
   input  logic       garrafa_aprovada,
   input  logic       alarme_rolha,
   output logic       motor_ativo,
   output logic       cmd_encher,
   output logic       cmd_vedar,
   output logic       cmd_cq,
   output logic       incrementar_garrafa,
   output logic [6:0] garrafas_lote,
   output logic       lote_concluido,
   output logic       falha_timeout,
`ifdef CONTAGEM_REJEITO_EN
   output logic [6:0] rejeitadas,
`endif
   output logic [3:0] estado
);

   // Counter loads are one less than the window: the count runs down to zero inclusive.
   localparam logic [TMR_W-1:0] MOVE_LD    = TMR_W'(MOVE_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LD = TMR_W'(TIMEOUT_CYCLES - 1);
   localparam logic [6:0]       ALVO       = 7'(LOTE_DUZIAS * DUZIA);

   estado_t    estado_q;
   logic       motor_q;
   logic       cmd_encher_q;
   logic       cmd_vedar_q;
   logic       cmd_cq_q;
   logic       inc_q;
   logic [6:0] garrafas_q;
   logic       lote_q;
   logic       falha_q;
`ifdef CONTAGEM_REJEITO_EN
   localparam logic [7:0] MAX_SEG = 8'(MAX_REJ_SEGUIDAS);
   logic [6:0] rej_q;
   logic [7:0] rej_seg_q;
`endif

   logic             tmr_done;
   logic             tmr_load;
   logic             tmr_clear;
   logic             tmr_en;
   logic [TMR_W-1:0] tmr_val;
   logic             avanca;

   // Timer control: reload on every state exit, freeze while the cork alarm pauses sealing.
   always_comb begin
      avanca = 1'b0;
      case (estado_q)
         S_IDLE, S_FIM_LOTE:                          avanca = iniciar;
         S_MOVE_ENCH, S_MOVE_VED, S_MOVE_CQ, S_MOVE_SAIDA: avanca = tmr_done;
         S_ENCHER:                                    avanca = enchimento_concluido;
         S_VEDAR:                                     avanca = vedacao_concluida;
         S_INSPEC:                                    avanca = cq_concluida;
         default:                                     avanca = 1'b0;
      endcase
      tmr_load  = avanca;
      tmr_val   = move_para_estacao(estado_q) ? TIMEOUT_LD : MOVE_LD;
      tmr_clear = (estado_q == S_IDLE) || (estado_q == S_FIM_LOTE) || (estado_q == S_FALHA);
      tmr_en    = eh_movimento(estado_q) || (estado_q == S_ENCHER) || (estado_q == S_INSPEC)
                  || ((estado_q == S_VEDAR) && !alarme_rolha);
   end

   sequenciador_linha_temporizador_ciclos #(
      .W (TMR_W)
   ) u_temporizador (
      .clk        (clk),
      .reset      (reset),
      .clear_i    (tmr_clear),
      .load_i     (tmr_load),
      .load_val_i (tmr_val),
      .en_i       (tmr_en),
      .done_o     (tmr_done)
   );

   // Sequencer FSM with registered outputs; a done pulse beats a coincident timeout.
   always_ff @(posedge clk) begin
      if (reset) begin
         estado_q     <= S_IDLE;
         motor_q      <= 1'b0;
         cmd_encher_q <= 1'b0;
         cmd_vedar_q  <= 1'b0;
         cmd_cq_q     <= 1'b0;
         inc_q        <= 1'b0;
         garrafas_q   <= '0;
         lote_q       <= 1'b0;
         falha_q      <= 1'b0;
`ifdef CONTAGEM_REJEITO_EN
         rej_q        <= '0;
         rej_seg_q    <= '0;
`endif
      end else begin
         inc_q <= 1'b0;
         case (estado_q)
            S_IDLE: begin
               if (iniciar) begin
                  estado_q <= S_MOVE_ENCH;
                  motor_q  <= 1'b1;
               end
            end
            S_MOVE_ENCH: begin
               if (tmr_done) begin
                  estado_q     <= S_ENCHER;
                  motor_q      <= 1'b0;
                  cmd_encher_q <= 1'b1;
               end
            end
            S_ENCHER: begin
               if (enchimento_concluido) begin
                  estado_q     <= S_MOVE_VED;
                  cmd_encher_q <= 1'b0;
                  motor_q      <= 1'b1;
               end else if (tmr_done) begin
                  estado_q     <= S_FALHA;
                  cmd_encher_q <= 1'b0;
                  falha_q      <= 1'b1;
               end
            end
            S_MOVE_VED: begin
               if (tmr_done) begin
                  estado_q    <= S_VEDAR;
                  motor_q     <= 1'b0;
                  cmd_vedar_q <= !alarme_rolha;
               end
            end
            S_VEDAR: begin
               if (vedacao_concluida) begin
                  estado_q    <= S_MOVE_CQ;
                  cmd_vedar_q <= 1'b0;
                  motor_q     <= 1'b1;
               end else if (tmr_done && !alarme_rolha) begin
                  estado_q    <= S_FALHA;
                  cmd_vedar_q <= 1'b0;
                  falha_q     <= 1'b1;
               end else begin
                  cmd_vedar_q <= !alarme_rolha;
               end
            end
            S_MOVE_CQ: begin
               if (tmr_done) begin
                  estado_q <= S_INSPEC;
                  motor_q  <= 1'b0;
                  cmd_cq_q <= 1'b1;
               end
            end
            S_INSPEC: begin
               if (cq_concluida) begin
                  cmd_cq_q <= 1'b0;
                  if (garrafa_aprovada) begin
                     inc_q      <= 1'b1;
                     garrafas_q <= garrafas_q + 7'd1;
                     estado_q   <= S_MOVE_SAIDA;
                     motor_q    <= 1'b1;
`ifdef CONTAGEM_REJEITO_EN
                     rej_seg_q  <= '0;
`endif
                  end else begin
`ifdef CONTAGEM_REJEITO_EN
                     if (rej_q != 7'd99) begin
                        rej_q <= rej_q + 7'd1;
                     end
                     if ((rej_seg_q + 8'd1) >= MAX_SEG) begin
                        estado_q <= S_FALHA;
                        falha_q  <= 1'b1;
                     end else begin
                        rej_seg_q <= rej_seg_q + 8'd1;
                        estado_q  <= S_MOVE_SAIDA;
                        motor_q   <= 1'b1;
                     end
`else
                     estado_q <= S_MOVE_SAIDA;
                     motor_q  <= 1'b1;
`endif
                  end
               end else if (tmr_done) begin
                  estado_q <= S_FALHA;
                  cmd_cq_q <= 1'b0;
                  falha_q  <= 1'b1;
               end
            end
            S_MOVE_SAIDA: begin
               if (tmr_done) begin
                  if (garrafas_q == ALVO) begin
                     estado_q <= S_FIM_LOTE;
                     motor_q  <= 1'b0;
                     lote_q   <= 1'b1;
                  end else if (parar) begin
                     estado_q <= S_IDLE;
                     motor_q  <= 1'b0;
                  end else begin
                     estado_q <= S_MOVE_ENCH;
                  end
               end
            end
            S_FIM_LOTE: begin
               if (iniciar) begin
                  estado_q   <= S_MOVE_ENCH;
                  motor_q    <= 1'b1;
                  garrafas_q <= '0;
                  lote_q     <= 1'b0;
`ifdef CONTAGEM_REJEITO_EN
                  rej_q      <= '0;
`endif
               end
            end
            S_FALHA: begin
               motor_q      <= 1'b0;
               cmd_encher_q <= 1'b0;
               cmd_vedar_q  <= 1'b0;
               cmd_cq_q     <= 1'b0;
               falha_q      <= 1'b1;
            end
            default: begin
               estado_q <= S_IDLE;
            end
         endcase
      end
   end

   assign motor_ativo         = motor_q;
   assign cmd_encher          = cmd_encher_q;
   assign cmd_vedar           = cmd_vedar_q;
   assign cmd_cq              = cmd_cq_q;
   assign incrementar_garrafa = inc_q;
   assign garrafas_lote       = garrafas_q;
   assign lote_concluido      = lote_q;
   assign falha_timeout       = falha_q;
   assign estado              = estado_q;
`ifdef CONTAGEM_REJEITO_EN
   assign rejeitadas          = rej_q;
`endif

endmodule

// File: tb/tb_sequenciador_linha.sv
// Bench for sequenciador_linha with short move/timeout windows.
// Approved bottles push their expected batch count into a queue; each
// incrementar_garrafa pulse pops and compares it.
`timescale 1ns/1ps
module tb_sequenciador_linha;
   import sequenciador_linha_pkg::*;

   localparam int MC = 4;
   localparam int TC = 20;
   localparam int LD = 1;

   logic       clk = 1'b0;
   logic       reset, iniciar, parar, enc_c, ved_c, cq_c, aprov, alarme;
   logic       motor, cmd_e, cmd_v, cmd_c, inc, lote, falha;
   logic [6:0] garrafas;
   logic [3:0] estado;

   int n_checks = 0;
   int n_err    = 0;
   int fila[$];
   int exp_garrafas = 0;

   always #5 clk = ~clk;

   sequenciador_linha #(
      .MOVE_CYCLES    (MC),
      .TIMEOUT_CYCLES (TC),
      .LOTE_DUZIAS    (LD)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .iniciar              (iniciar),
      .parar                (parar),
      .enchimento_concluido (enc_c),
      .vedacao_concluida    (ved_c),
      .cq_concluida         (cq_c),
      .garrafa_aprovada     (aprov),
      .alarme_rolha         (alarme),
      .motor_ativo          (motor),
      .cmd_encher           (cmd_e),
      .cmd_vedar            (cmd_v),
      .cmd_cq               (cmd_c),
      .incrementar_garrafa  (inc),
      .garrafas_lote        (garrafas),
      .lote_concluido       (lote),
      .falha_timeout        (falha),
      .estado               (estado)
   );

   task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
      n_checks++;
      if (obs !== esp) begin
         n_err++;
         $display("FAIL %s: obtido=%0d esperado=%0d", tag, obs, esp);
      end
   endtask

   // Scoreboard: every increment pulse must match a queued approved bottle.
   always @(negedge clk) begin
      if (inc === 1'b1) begin
         verifica("inc_com_esperado", fila.size() > 0, 1);
         if (fila.size() > 0) verifica("garrafas_sb", garrafas, fila.pop_front());
      end
   end

   initial begin
      #500_000;
      $display("FAIL watchdog: simulacao sem fim");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulsa_iniciar();
      iniciar = 1'b1;
      tick();
      iniciar = 1'b0;
   endtask

   function automatic logic cmd_de(input int sel);
      case (sel)
         0:       return cmd_e;
         1:       return cmd_v;
         default: return cmd_c;
      endcase
   endfunction

   task automatic espera_cmd(input int sel);
      int k = 0;
      @(negedge clk);
      while (cmd_de(sel) !== 1'b1 && k < 60) begin
         @(negedge clk);
         k++;
      end
      verifica($sformatf("cmd%0d_ativo", sel), cmd_de(sel), 1);
   endtask

   task automatic pulsa_done(input int sel, input bit ap);
      repeat (3) @(posedge clk);
      #1;
      case (sel)
         0: enc_c = 1'b1;
         1: ved_c = 1'b1;
         default: begin
            cq_c  = 1'b1;
            aprov = ap;
            if (ap) begin
               exp_garrafas++;
               fila.push_back(exp_garrafas);
            end
         end
      endcase
      tick();
      enc_c = 1'b0; ved_c = 1'b0; cq_c = 1'b0; aprov = 1'b0;
      @(negedge clk);
      verifica($sformatf("latencia_motor%0d", sel), motor, 1);
   endtask

   task automatic garrafa(input bit ap);
      espera_cmd(0); pulsa_done(0, 1'b0);
      espera_cmd(1); pulsa_done(1, 1'b0);
      espera_cmd(2); pulsa_done(2, ap);
   endtask

   initial begin
      int n;
      reset = 1'b1; iniciar = 1'b0; parar = 1'b0; enc_c = 1'b0; ved_c = 1'b0;
      cq_c = 1'b0; aprov = 1'b0; alarme = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
      @(negedge clk);
      verifica("rst_estado", estado, S_IDLE);
      verifica("rst_motor", motor, 0);
      verifica("rst_cmds", {cmd_e, cmd_v, cmd_c, inc}, 0);
      verifica("rst_garrafas", garrafas, 0);
      verifica("rst_lote_falha", {lote, falha}, 0);

      // First move: motor high exactly MC cycles, then fill station
      pulsa_iniciar();
      n = 0;
      @(negedge clk);
      while (motor === 1'b1 && n < 100) begin
         n++;
         @(negedge clk);
      end
      verifica("motor_ciclos", n, MC);
      verifica("estado_encher", estado, S_ENCHER);
      verifica("cmd_encher", cmd_e, 1);

      // One approved bottle, back to fill
      garrafa(1'b1);
      espera_cmd(0);
      verifica("volta_encher", estado, S_ENCHER);
      verifica("garrafas_1", garrafas, 1);

      // Rest of the batch
      for (int i = 2; i <= 12; i++) garrafa(1'b1);
      n = 0;
      while (lote !== 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      verifica("lote_concluido", lote, 1);
      verifica("estado_fim_lote", estado, S_FIM_LOTE);
      verifica("garrafas_12", garrafas, 12);
      repeat (5) @(negedge clk);
      verifica("motor_parado_fim", motor, 0);
      verifica("lote_mantido", lote, 1);

      // New batch
      pulsa_iniciar();
      exp_garrafas = 0;
      @(negedge clk);
      verifica("novo_lote_garrafas", garrafas, 0);
      verifica("novo_lote_flag", lote, 0);
      verifica("novo_lote_motor", motor, 1);

      // Cork alarm pauses sealing without fault
      espera_cmd(0); pulsa_done(0, 1'b0);
      espera_cmd(1);
      alarme = 1'b1;
      repeat (5) @(negedge clk);
      verifica("alarme_cmd_vedar", cmd_v, 0);
      repeat (35) @(negedge clk);
      verifica("alarme_sem_falha", falha, 0);
      verifica("alarme_estado", estado, S_VEDAR);
      alarme = 1'b0;
      repeat (2) @(negedge clk);
      verifica("alarme_liberado", cmd_v, 1);
      pulsa_done(1, 1'b0);
      espera_cmd(2); pulsa_done(2, 1'b1);

      // parar with a rejected bottle: no count, IDLE, resume batch
      espera_cmd(0); pulsa_done(0, 1'b0);
      espera_cmd(1); pulsa_done(1, 1'b0);
      espera_cmd(2);
      parar = 1'b1;
      pulsa_done(2, 1'b0);
      n = 0;
      while (motor === 1'b1 && n < 40) begin
         @(negedge clk);
         n++;
      end
      verifica("parar_estado", estado, S_IDLE);
      verifica("parar_garrafas", garrafas, 1);
      parar = 1'b0;
      repeat (3) @(negedge clk);
      verifica("parar_fica_idle", estado, S_IDLE);
      pulsa_iniciar();
      @(negedge clk);
      verifica("retoma_motor", motor, 1);
      verifica("retoma_garrafas", garrafas, 1);
      garrafa(1'b1);

      // Done pulse on the very cycle the timeout expires
      espera_cmd(0);
      repeat (TC - 1) @(posedge clk);
      #1 enc_c = 1'b1;
      tick();
      enc_c = 1'b0;
      @(negedge clk);
      verifica("done_vence_falha", falha, 0);
      verifica("done_vence_estado", estado, S_MOVE_VED);
      espera_cmd(1); pulsa_done(1, 1'b0);
      espera_cmd(2); pulsa_done(2, 1'b1);

      // Fill station never answers: fault after TC cycles
      espera_cmd(0);
      n = 0;
      while (falha !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      verifica("timeout_ciclos", n, TC);
      verifica("falha_estado", estado, S_FALHA);
      verifica("falha_saidas", {motor, cmd_e, cmd_v, cmd_c}, 0);
      pulsa_iniciar();
      repeat (3) @(negedge clk);
      verifica("falha_ignora_iniciar", estado, S_FALHA);
      verifica("falha_motor", motor, 0);
      verifica("falha_sticky", falha, 1);

      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      verifica("pos_reset_estado", estado, S_IDLE);
      verifica("pos_reset_falha", falha, 0);
      verifica("pos_reset_garrafas", garrafas, 0);
      verifica("fila_vazia", fila.size(), 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
